// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative HI/LO multiply/divide unit for the MIPS core.
// One result bit per cycle via shift-add multiply or restoring divide,
// followed by a sign-fix step and a registered write of HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [1:0]           op_r;
    logic                 sa_r;
    logic                 sb_r;
    logic                 divz_r;
    logic                 fin_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 dbz_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 accept_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       trial_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   fix_s;

    // Magnitude of a WIDTH-bit operand; the most negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negation of a WIDTH-bit value, wrapping mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of the full 2*WIDTH product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // A start is only taken once the previous result has been published (busy low).
    always_comb begin
        accept_s = (state_r == IDLE) && !busy_r && start;
        a_neg_s  = op[0] & a[WIDTH-1];
        b_neg_s  = op[0] & b[WIDTH-1];
    end

    // One iteration of each datapath plus the final sign correction.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        trial_s    = rem_sh_s - {1'b0, b_r};
        if (!trial_s[WIDTH]) begin
            div_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
        if (!op_r[1]) begin
            fix_s = (sa_r ^ sb_r) ? neg_2w(acc_r) : acc_r;
        end else begin
            fix_s[WIDTH-1:0]       = (sa_r ^ sb_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            fix_s[2*WIDTH-1:WIDTH] = sa_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (op[1] && (b == {WIDTH{1'b0}})) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration, sign fix and the registered HI/LO/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= 2'b00;
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
            divz_r <= 1'b0;
            fin_r  <= 1'b0;
            b_r    <= {WIDTH{1'b0}};
            acc_r  <= {(2*WIDTH){1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            // busy trails the FSM by one cycle so it drops on the edge done rises
            busy_r <= (state_r != IDLE);
            fin_r  <= (state_r == FIX);
            done_r <= fin_r;
            if (fin_r) begin
                if (divz_r) begin
                    dbz_r <= 1'b1;
                end else begin
                    hi_r <= acc_r[2*WIDTH-1:WIDTH];
                    lo_r <= acc_r[WIDTH-1:0];
                end
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r   <= op;
                        sa_r   <= a_neg_s;
                        sb_r   <= b_neg_s;
                        b_r    <= abs_val(b, b_neg_s);
                        acc_r  <= {{WIDTH{1'b0}}, abs_val(a, a_neg_s)};
                        cnt_r  <= CW'(WIDTH);
                        divz_r <= op[1] && (b == {WIDTH{1'b0}});
                        dbz_r  <= 1'b0;
                    end else if (!busy_r) begin
                        if (hilo_wr[1]) begin
                            hi_r <= wdata;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (hilo_wr[0]) begin
                            lo_r <= wdata;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                CALC: begin
                    acc_r <= op_r[1] ? div_next_s : mul_next_s;
                    cnt_r <= cnt_r - CW'(1);
                end
                FIX: begin
                    if (!divz_r) begin
                        acc_r <= fix_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign dbz  = dbz_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus hand-written
// sequences, expected results queued at launch and compared when done pulses.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  hilo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_wr(hilo_wr), .wdata(wdata), .busy(busy), .done(done), .dbz(dbz),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        dz;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[12];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one start cycle from the current negedge and queue the expected result.
    task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic dz);
        exp_t e;
        start = 1'b1; op = o; a = va; b = vb;
        if (dz) begin
            e.hi = model_hi; e.lo = model_lo; e.dbz = 1'b1;
        end else begin
            e.hi = ehi; e.lo = elo; e.dbz = 1'b0;
        end
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; hilo_wr = 2'b00;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_op(input string nm, input int exp_lat, input int exp_busy);
        int   lat;
        int   bc;
        exp_t e;
        wait_done(lat, bc);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_busycycles"}, 64'(bc), 64'(exp_busy));
        if (lat > 0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_scoreboard: got done expected no result", nm);
            end else begin
                e = sb_q.pop_front();
                chk({nm, "_hi"}, 64'(hi), 64'(e.hi));
                chk({nm, "_lo"}, 64'(lo), 64'(e.lo));
                chk({nm, "_dbz"}, 64'(dbz), 64'(e.dbz));
                model_hi = e.hi;
                model_lo = e.lo;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[5]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b10, 32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000, 1'b0};
        vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{2'b10, 32'hDEADBEEF, 32'h00000010, 32'h0000000F, 32'h0DEADBEE, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hilo_wr = 2'b00; wdata = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(dbz), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        // Table of operations, each run to completion.
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].dz);
            chk($sformatf("vec%0d_busy_after_start", i), 64'(busy), 64'd0);
            finish_op($sformatf("vec%0d", i), vecs[i].dz ? 2 : 34, vecs[i].dz ? 1 : 33);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // MTHI then divide by zero: HI keeps the written value, LO untouched.
        hilo_wr = 2'b10; wdata = 32'h00001234;
        @(negedge clk);
        hilo_wr = 2'b00;
        model_hi = 32'h00001234;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_done", 64'(done), 64'd0);
        launch(2'b10, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
        finish_op("divu_by_zero", 2, 1);

        // MTLO alone, then both written at once.
        hilo_wr = 2'b01; wdata = 32'hCAFE0001;
        @(negedge clk);
        chk("mtlo_lo", 64'(lo), 64'hCAFE0001);
        chk("mtlo_hi_kept", 64'(hi), 64'h1234);
        hilo_wr = 2'b11; wdata = 32'h0BADF00D;
        @(negedge clk);
        hilo_wr = 2'b00;
        model_hi = 32'h0BADF00D; model_lo = 32'h0BADF00D;
        chk("mthilo_hi", 64'(hi), 64'h0BADF00D);
        chk("mthilo_lo", 64'(lo), 64'h0BADF00D);

        // start and hilo_wr together: the write is dropped.
        hilo_wr = 2'b11; wdata = 32'hFFFF0000;
        launch(2'b10, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1);
        finish_op("start_beats_write", 2, 1);

        // A write while busy is ignored.
        launch(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        repeat (4) @(negedge clk);
        hilo_wr = 2'b11; wdata = 32'h55555555;
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; hilo_wr = 2'b00;
        finish_op("start_while_busy", 29, 28);

        // Start in the done cycle is accepted.
        launch(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        chk("done_cycle_start_pulse", 64'(done), 64'd0);
        finish_op("done_cycle_start", 34, 33);

        // Reset mid-divide aborts, then a fresh op completes.
        @(negedge clk);
        launch(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        sb_q.delete();
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clk);
        launch(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        finish_op("after_reset", 34, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
